ans_freq_table: RTL and testbench

Parametrised symbol-frequency table for the rANS coder: it takes SYM_COUNT counts over a valid/ready stream and keeps running cumulative sums while loading. It then answers PMF, CMF and inverse-CMF (ICMF) queries through a query/response handshake. It sits between the host count-loader path and the encoder/decoder datapath. Compared with the previous loader it adds:
- O(1) CMF lookup;
- table reload without reset;
- an error flag;
- an optional logarithmic ICMF search.

---
 rtl/ans_pkg.sv | 22 ++
 rtl/ans_icmf_search.sv | 103 ++++++++++
 rtl/ans_freq_table.sv | 171 +++++++++++++++++
 tb/tb_ans_freq_table.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ans_pkg.sv
// Shared types and default sizing for the rANS frequency table and coder.
// Build option: ANS_FTAB_BSEARCH_EN selects the binary ICMF search.
package ans_pkg;

  localparam int SYM_COUNT_DEF = 16;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    RT_NONE = 2'b00,
    RT_PMF  = 2'b01,
    RT_CMF  = 2'b10,
    RT_ICMF = 2'b11
  } read_type_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_IDLE,
    ST_SEARCH,
    ST_RESP
  } state_t;

endpackage

// File: rtl/ans_icmf_search.sv
// Inverse-CMF search engine: linear scan by default, binary search
// when ANS_FTAB_BSEARCH_EN is defined.
module ans_icmf_search
  import ans_pkg::*;
#(
  parameter int SYM_COUNT = SYM_COUNT_DEF,
  parameter int SYM_W = $clog2(SYM_COUNT),
  parameter int CUM_W = CNT_W_DEF + SYM_W
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic [CUM_W-1:0] x,
  output logic [SYM_W-1:0] rd_idx,
  input  logic [CUM_W-1:0] rd_data,
  output logic [SYM_W-1:0] idx,
  output logic             done
);

  localparam logic [SYM_W:0] NSYM = (SYM_W+1)'(SYM_COUNT);

  logic [CUM_W-1:0] x_q;
  logic             busy;

`ifdef ANS_FTAB_BSEARCH_EN

  localparam logic [SYM_W-1:0] TOP = SYM_W'(1 << (SYM_W-1));

  logic [SYM_W-1:0] res;
  logic [SYM_W-1:0] mask;
  logic [SYM_W-1:0] cand;
  logic [SYM_W-1:0] res_nxt;
  logic             take;

  // One result bit per cycle, MSB first: keep the bit if cum[cand] <= x.
  always_comb begin
    cand    = res | mask;
    rd_idx  = cand;
    take    = ({1'b0, cand} < NSYM) && (rd_data <= x_q);
    res_nxt = take ? cand : res;
    idx     = res_nxt;
    done    = busy && mask[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      res  <= '0;
      mask <= '0;
      busy <= 1'b0;
    end else if (en) begin
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        x_q  <= x;
        res  <= '0;
        mask <= TOP;
        busy <= 1'b1;
      end else if (busy) begin
        res  <= res_nxt;
        mask <= mask >> 1;
        if (mask[0]) busy <= 1'b0;
      end
    end
  end

`else

  logic [SYM_W-1:0] cur;
  logic [SYM_W:0]   nxt;

  // Stop on the last symbol or when the next exclusive sum passes x.
  always_comb begin
    nxt    = {1'b0, cur} + (SYM_W+1)'(1);
    rd_idx = nxt[SYM_W-1:0];
    idx    = cur;
    done   = busy && ((nxt >= NSYM) || (rd_data > x_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      cur  <= '0;
      busy <= 1'b0;
    end else if (en) begin
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        x_q  <= x;
        cur  <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        if (done) busy <= 1'b0;
        else      cur  <= nxt[SYM_W-1:0];
      end
    end
  end

`endif

endmodule

// File: rtl/ans_freq_table.sv
// rANS symbol-frequency table: streamed count load, PMF/CMF/ICMF queries.
// Build option: ANS_FTAB_BSEARCH_EN selects the binary ICMF search.
module ans_freq_table
  import ans_pkg::*;
#(
  parameter int SYM_COUNT = SYM_COUNT_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SYM_W = $clog2(SYM_COUNT),
  parameter int CUM_W = CNT_W + SYM_W
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tbl_clr,
  input  logic [CNT_W-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic             tbl_rdy,
  output logic [CUM_W-1:0] tot,
  input  logic             q_vld,
  output logic             q_rdy,
  input  logic [1:0]       q_type,
  input  logic [CUM_W-1:0] q_arg,
  output logic             r_vld,
  input  logic             r_rdy,
  output logic [CUM_W-1:0] r_data,
  output logic             r_err
);

  localparam logic [SYM_W:0]   NSYM = (SYM_W+1)'(SYM_COUNT);
  localparam logic [SYM_W-1:0] LAST = SYM_W'(SYM_COUNT - 1);

  state_t state;
  state_t nxt;

  logic [SYM_W-1:0] ld_idx;
  logic [CUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt [SYM_COUNT];
  logic [CUM_W-1:0] cum [SYM_COUNT];

  logic             clr;
  logic             in_acc;
  logic             q_acc;
  logic             r_acc;
  logic             last_ld;
  logic             s_bad;
  logic             x_in;
  logic             srch_start;
  logic             srch_done;
  logic [SYM_W-1:0] q_sym;
  logic [SYM_W-1:0] rd_idx;
  logic [SYM_W-1:0] srch_idx;
  logic [CUM_W-1:0] rd_data;
  logic [CUM_W-1:0] q_res;
  logic             q_err;
  read_type_t       q_kind;

  assign in_rdy  = state == ST_LOAD;
  assign tbl_rdy = !in_rdy;
  assign tot     = tbl_rdy ? sum : '0;
  assign q_rdy   = state == ST_IDLE;
  assign r_vld   = state == ST_RESP;

  assign clr    = en && tbl_clr;
  assign in_acc = en && !tbl_clr && in_vld && in_rdy;
  assign q_acc  = en && !tbl_clr && q_vld && q_rdy;
  assign r_acc  = en && !tbl_clr && r_vld && r_rdy;

  assign last_ld    = ld_idx == LAST;
  assign q_sym      = q_arg[SYM_W-1:0];
  assign q_kind     = read_type_t'(q_type);
  assign s_bad      = {1'b0, q_sym} >= NSYM;
  assign x_in       = q_arg < sum;
  assign srch_start = q_acc && (q_kind == RT_ICMF) && x_in;

  // Out-of-range reads look larger than any x so the search stops there.
  assign rd_data = ({1'b0, rd_idx} < NSYM) ? cum[rd_idx] : '1;

  always_comb begin
    q_res = '0;
    q_err = 1'b0;
    unique case (1'b1)
      q_kind == RT_PMF: begin
        if (s_bad) q_err = 1'b1;
        else       q_res = CUM_W'(cnt[q_sym]);
      end
      q_kind == RT_CMF: begin
        if (s_bad) q_err = 1'b1;
        else       q_res = cum[q_sym];
      end
      q_kind == RT_ICMF: begin
        if (!x_in) begin
          q_res = CUM_W'(LAST);
          q_err = 1'b1;
        end
      end
      default: q_err = 1'b1;
    endcase
  end

  always_comb begin
    nxt = state;
    if (clr) begin
      nxt = ST_LOAD;
    end else if (en) begin
      unique case (state)
        ST_LOAD:   if (in_acc && last_ld) nxt = ST_IDLE;
        ST_IDLE:   if (q_acc) nxt = srch_start ? ST_SEARCH : ST_RESP;
        ST_SEARCH: if (srch_done) nxt = ST_RESP;
        ST_RESP:   if (r_acc) nxt = ST_IDLE;
        default:   nxt = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_idx <= '0;
      sum    <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
      for (int i = 0; i < SYM_COUNT; i++) begin
        cnt[i] <= '0;
        cum[i] <= '0;
      end
    end else if (en) begin
      if (tbl_clr) begin
        ld_idx <= '0;
        sum    <= '0;
      end else begin
        if (in_acc) begin
          cnt[ld_idx] <= in_data;
          cum[ld_idx] <= sum;
          sum         <= sum + CUM_W'(in_data);
          ld_idx      <= ld_idx + SYM_W'(1);
        end
        if (q_acc) begin
          r_data <= q_res;
          r_err  <= q_err;
        end
        if (state == ST_SEARCH && srch_done) begin
          r_data <= CUM_W'(srch_idx);
          r_err  <= 1'b0;
        end
      end
    end
  end

  ans_icmf_search #(
    .SYM_COUNT(SYM_COUNT),
    .SYM_W(SYM_W),
    .CUM_W(CUM_W)
  ) u_search (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .start(srch_start),
    .abort(clr),
    .x(q_arg),
    .rd_idx(rd_idx),
    .rd_data(rd_data),
    .idx(srch_idx),
    .done(srch_done)
  );

endmodule

// File: tb/tb_ans_freq_table.sv
// Directed bench for ans_freq_table: 4-symbol and 5-symbol instances.
// Honours ANS_FTAB_BSEARCH_EN for ICMF latency expectations.
module tb_ans_freq_table;

`ifdef ANS_FTAB_BSEARCH_EN
  localparam bit BS = 1'b1;
`else
  localparam bit BS = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       tbl_clr;
  logic [3:0] in_data;
  logic       in_vld;
  logic       in_rdy;
  logic       tbl_rdy;
  logic [5:0] tot;
  logic       q_vld;
  logic       q_rdy;
  logic [1:0] q_type;
  logic [5:0] q_arg;
  logic       r_vld;
  logic       r_rdy;
  logic [5:0] r_data;
  logic       r_err;

  logic       b_en;
  logic       b_clr;
  logic [3:0] b_in_data;
  logic       b_in_vld;
  logic       b_in_rdy;
  logic       b_tbl_rdy;
  logic [6:0] b_tot;
  logic       b_q_vld;
  logic       b_q_rdy;
  logic [1:0] b_q_type;
  logic [6:0] b_q_arg;
  logic       b_r_vld;
  logic       b_r_rdy;
  logic [6:0] b_r_data;
  logic       b_r_err;

  int checks = 0;
  int errors = 0;

  ans_freq_table #(.SYM_COUNT(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tbl_clr(tbl_clr),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .tbl_rdy(tbl_rdy), .tot(tot),
    .q_vld(q_vld), .q_rdy(q_rdy), .q_type(q_type), .q_arg(q_arg),
    .r_vld(r_vld), .r_rdy(r_rdy), .r_data(r_data), .r_err(r_err)
  );

  ans_freq_table #(.SYM_COUNT(5), .CNT_W(4)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(b_en), .tbl_clr(b_clr),
    .in_data(b_in_data), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
    .tbl_rdy(b_tbl_rdy), .tot(b_tot),
    .q_vld(b_q_vld), .q_rdy(b_q_rdy), .q_type(b_q_type),
    .q_arg(b_q_arg),
    .r_vld(b_r_vld), .r_rdy(b_r_rdy), .r_data(b_r_data),
    .r_err(b_r_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int icmf_lat(input int s);
    return BS ? 3 : s + 2;
  endfunction

  task automatic load4(input logic [15:0] v);
    int acc;
    acc = 0;
    in_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = v[4*i +: 4];
      if (in_rdy) acc++;
      step();
    end
    in_vld = 1'b0;
    check("load.accepts", acc, 4);
    check("load.tbl_rdy", tbl_rdy, 1);
    check("load.in_rdy", in_rdy, 0);
  endtask

  task automatic qchk(input string tag, input logic [1:0] t,
                      input logic [5:0] a, input logic [5:0] ed,
                      input logic ee, input int el);
    int lat;
    check({tag, ".q_rdy"}, q_rdy, 1);
    q_type = t;
    q_arg  = a;
    q_vld  = 1'b1;
    step();
    q_vld = 1'b0;
    lat = 1;
    while (!r_vld && lat < 40) begin
      step();
      lat++;
    end
    check({tag, ".data"}, r_data, ed);
    check({tag, ".err"}, r_err, ee);
    check({tag, ".lat"}, lat, el);
    r_rdy = 1'b1;
    step();
    r_rdy = 1'b0;
  endtask

  task automatic bq(input string tag, input logic [1:0] t,
                    input logic [6:0] a, input logic [6:0] ed,
                    input logic ee);
    b_q_type = t;
    b_q_arg  = a;
    b_q_vld  = 1'b1;
    step();
    b_q_vld = 1'b0;
    check({tag, ".vld"}, b_r_vld, 1);
    check({tag, ".data"}, b_r_data, ed);
    check({tag, ".err"}, b_r_err, ee);
    b_r_rdy = 1'b1;
    step();
    b_r_rdy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b1; tbl_clr = 1'b0;
    in_data = '0; in_vld = 1'b0; q_vld = 1'b0;
    q_type = '0; q_arg = '0; r_rdy = 1'b0;
    b_en = 1'b1; b_clr = 1'b0; b_in_data = '0; b_in_vld = 1'b0;
    b_q_vld = 1'b0; b_q_type = '0; b_q_arg = '0; b_r_rdy = 1'b0;
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst.in_rdy", in_rdy, 1);
    check("rst.tbl_rdy", tbl_rdy, 0);
    check("rst.tot", tot, 0);
    check("rst.q_rdy", q_rdy, 0);
    check("rst.r_vld", r_vld, 0);
    check("rst.r_data", r_data, 0);
    check("rst.r_err", r_err, 0);
    rst_n = 1'b1;
    step();

    load4(16'h8503);
    check("load.tot", tot, 16);

    qchk("pmf2", 2'b01, 6'd2, 6'd5, 1'b0, 1);
    qchk("cmf3", 2'b10, 6'd3, 6'd8, 1'b0, 1);
    qchk("cmf0", 2'b10, 6'd0, 6'd0, 1'b0, 1);
    qchk("cmf1", 2'b10, 6'd1, 6'd3, 1'b0, 1);
    qchk("icmf0", 2'b11, 6'd0, 6'd0, 1'b0, icmf_lat(0));
    qchk("icmf2", 2'b11, 6'd2, 6'd0, 1'b0, icmf_lat(0));
    qchk("icmf3", 2'b11, 6'd3, 6'd2, 1'b0, icmf_lat(2));
    qchk("icmf15", 2'b11, 6'd15, 6'd3, 1'b0, icmf_lat(3));
    qchk("icmf16", 2'b11, 6'd16, 6'd3, 1'b1, 1);
    qchk("rsvd", 2'b00, 6'd1, 6'd0, 1'b1, 1);

    q_type = 2'b01; q_arg = 6'd3; q_vld = 1'b1;
    step();
    q_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp.r_vld", r_vld, 1);
      check("bp.r_data", r_data, 8);
      check("bp.q_rdy", q_rdy, 0);
      step();
    end
    r_rdy = 1'b1;
    step();
    r_rdy = 1'b0;
    check("bp.release", q_rdy, 1);

    q_type = 2'b11; q_arg = 6'd15; q_vld = 1'b1;
    step();
    q_vld = 1'b0;
    check("abort.pre", r_vld, 0);
    tbl_clr = 1'b1;
    step();
    tbl_clr = 1'b0;
    check("abort.in_rdy", in_rdy, 1);
    check("abort.tbl_rdy", tbl_rdy, 0);
    check("abort.tot", tot, 0);
    for (int i = 0; i < 6; i++) begin
      check("abort.r_vld", r_vld, 0);
      step();
    end

    in_vld = 1'b1;
    in_data = 4'd1;
    step();
    step();
    en = 1'b0;
    in_data = 4'd7;
    step();
    step();
    step();
    check("en.tbl_rdy", tbl_rdy, 0);
    check("en.in_rdy", in_rdy, 1);
    en = 1'b1;
    in_data = 4'd1;
    step();
    check("en.partial", tbl_rdy, 0);
    step();
    in_vld = 1'b0;
    check("reload.tbl_rdy", tbl_rdy, 1);
    check("reload.tot", tot, 4);
    qchk("reload.icmf2", 2'b11, 6'd2, 6'd2, 1'b0, icmf_lat(2));

    b_in_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in_data = 4'(i + 1);
      step();
    end
    b_in_vld = 1'b0;
    check("b.tbl_rdy", b_tbl_rdy, 1);
    check("b.tot", b_tot, 15);
    bq("b.cmf6", 2'b10, 7'd6, 7'd0, 1'b1);
    bq("b.cmf4", 2'b10, 7'd4, 7'd10, 1'b0);
    bq("b.pmf4", 2'b01, 7'd4, 7'd5, 1'b0);

    q_type = 2'b01; q_arg = 6'd0; q_vld = 1'b1;
    step();
    q_vld = 1'b0;
    check("rst2.pre", r_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2.r_vld", r_vld, 0);
    check("rst2.tbl_rdy", tbl_rdy, 0);
    check("rst2.in_rdy", in_rdy, 1);
    check("rst2.r_data", r_data, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
